// File: rtl/seq_ripple_adder_pkg.sv
// ---------------------------------------------------------------------------
// seq_ripple_adder_pkg
// Shared definitions for the multi-cycle ripple adder/subtractor:
//   - state_e   : controller state codes (2-bit state register)
//   - cnt_width : digit-counter width for a given digit count (minimum 1)
// ---------------------------------------------------------------------------
package seq_ripple_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A single-digit operation still needs a 1-bit counter so the register exists.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/seq_ripple_adder_if.sv
// ---------------------------------------------------------------------------
// seq_ripple_adder_if
// Request/result bundle of the sequential ripple adder.
//   master : drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the adder itself (opposite directions)
// ---------------------------------------------------------------------------
interface seq_ripple_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_ripple_adder_rca_digit.sv
// ---------------------------------------------------------------------------
// rca_digit
// Combinational DIGIT-bit ripple-carry slice built from a full-adder chain.
//   x, y  : digit operands
//   ci    : carry into bit 0
//   s     : digit sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (with co gives signed overflow)
// ---------------------------------------------------------------------------
module rca_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_ripple_adder.sv
// ---------------------------------------------------------------------------
// seq_ripple_adder
// Multi-cycle ripple adder/subtractor: adds DIGIT bits per clock, LSB digit
// first, through a single rca_digit slice.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_ripple_adder_if.slave
//           start/sub/a/b/cin in (sampled when idle or done),
//           busy/done/sum/cout/ovf out
// sub=1 computes a + ~b + 1 (cin ignored); cout=1 then means no borrow.
// sum/cout/ovf update only on the completion edge.
// ---------------------------------------------------------------------------
module seq_ripple_adder
  import seq_ripple_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_ripple_adder_if.slave    bus
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
  localparam int unsigned DIGIT_U = DIGIT;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             c_q,     c_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic             accept;
  int unsigned      lsb;
  logic [DIGIT-1:0] x, y, s;
  logic             co, c_msb;

  // Bit position of the digit being processed this cycle.
  assign lsb = DIGIT_U * 32'(cnt_q);
  assign x   = a_q[lsb +: DIGIT];
  assign y   = b_q[lsb +: DIGIT];

  rca_digit #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x     (x),
    .y     (y),
    .ci    (c_q),
    .s     (s),
    .co    (co),
    .c_msb (c_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;

    case (state_q)
      S_IDLE: accept = bus.start;
      S_RUN: begin
        res_d[lsb +: DIGIT] = s;
        c_d   = co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final digit: publish the complete result in one step so
          // partial sums never reach the outputs.
          state_d = S_DONE;
          cnt_d   = '0;
          sum_d   = res_d;
          cout_d  = co;
          ovf_d   = c_msb ^ co;
        end
      end
      // DONE accepts a new request directly for back-to-back operation.
      S_DONE: begin
        state_d = S_IDLE;
        accept  = bus.start;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_RUN;
      cnt_d   = '0;
      a_d     = bus.a;
      b_d     = bus.sub ? ~bus.b : bus.b;
      c_d     = bus.sub ? 1'b1 : bus.cin;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_ripple_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_ripple_adder
// Three adder instances (8/2, 4/1, 8/8) share one stimulus set; sel picks
// which one receives start and whose outputs are observed. Expected results
// are queued when a request is driven and compared on each done pulse.
// ---------------------------------------------------------------------------
module tb_seq_ripple_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_t, sub_t, cin_t;
  logic [7:0] a_t, b_t;
  int         sel;

  seq_ripple_adder_if #(.WIDTH(8)) if_a ();
  seq_ripple_adder_if #(.WIDTH(4)) if_b ();
  seq_ripple_adder_if #(.WIDTH(8)) if_c ();

  assign if_a.start = start_t && (sel == 0);
  assign if_a.sub   = sub_t;
  assign if_a.a     = a_t;
  assign if_a.b     = b_t;
  assign if_a.cin   = cin_t;

  assign if_b.start = start_t && (sel == 1);
  assign if_b.sub   = sub_t;
  assign if_b.a     = a_t[3:0];
  assign if_b.b     = b_t[3:0];
  assign if_b.cin   = cin_t;

  assign if_c.start = start_t && (sel == 2);
  assign if_c.sub   = sub_t;
  assign if_c.a     = a_t;
  assign if_c.b     = b_t;
  assign if_c.cin   = cin_t;

  seq_ripple_adder #(.WIDTH(8), .DIGIT(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  seq_ripple_adder #(.WIDTH(4), .DIGIT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  seq_ripple_adder #(.WIDTH(8), .DIGIT(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  logic       busy_m, done_m, cout_m, ovf_m;
  logic [7:0] sum_m;

  always_comb begin
    busy_m = if_a.busy; done_m = if_a.done; sum_m = if_a.sum;
    cout_m = if_a.cout; ovf_m  = if_a.ovf;
    case (sel)
      1: begin
        busy_m = if_b.busy; done_m = if_b.done; sum_m = {4'h0, if_b.sum};
        cout_m = if_b.cout; ovf_m  = if_b.ovf;
      end
      2: begin
        busy_m = if_c.busy; done_m = if_c.done; sum_m = if_c.sum;
        cout_m = if_c.cout; ovf_m  = if_c.ovf;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         k;
    int         ndig;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   busy_run = 0;
  logic [7:0] last_sum = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cur_w();
    return (sel == 1) ? 4 : 8;
  endfunction

  function automatic int cur_ndig();
    return (sel == 2) ? 1 : 4;
  endfunction

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic exp_t model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input int k);
    exp_t       e;
    int         w;
    logic [7:0] mask, am, bx;
    logic [8:0] full;
    logic       c0;
    w    = cur_w();
    mask = (w == 8) ? 8'hFF : 8'h0F;
    am   = a & mask;
    bx   = (sub ? ~b : b) & mask;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, am} + {1'b0, bx} + {8'h00, c0};
    e.sum  = full[7:0] & mask;
    e.cout = full[w];
    e.ovf  = (am[w-1] == bx[w-1]) && (full[w-1] != am[w-1]);
    e.k    = k;
    e.ndig = cur_ndig();
    return e;
  endfunction

  // Call just after a falling edge; returns after the next falling edge.
  task automatic issue(input logic sub, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input bit accepted);
    sub_t = sub; a_t = a; b_t = b; cin_t = cin; start_t = 1'b1;
    if (accepted) sbq.push_back(model(sub, a, b, cin, cyc + 1));
    @(posedge clk);
    @(negedge clk);
    start_t = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sbq.size()), 32'd0);
    if (sbq.size() != 0) sbq.delete();
    @(negedge clk);
  endtask

  task automatic wait_done_pulse();
    int n = 0;
    @(negedge clk);
    while (!done_m && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done_m), 32'd1);
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      chk("busy_done_excl", 32'(busy_m & done_m), 32'd0);
      if (busy_m) busy_run++;
      if (done_m) begin
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("sum",     32'(sum_m),    32'(e.sum));
          chk("cout",    32'(cout_m),   32'(e.cout));
          chk("ovf",     32'(ovf_m),    32'(e.ovf));
          chk("latency", 32'(cyc - e.k), 32'(e.ndig));
          chk("busy_cycles", 32'(busy_run), 32'(e.ndig));
          last_sum = e.sum;
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start_t = 1'b0; sub_t = 1'b0; cin_t = 1'b0;
    a_t = 8'h00; b_t = 8'h00; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_done", 32'(done_m), 32'd0);
    chk("rst_sum",  32'(sum_m),  32'd0);
    chk("rst_cout", 32'(cout_m), 32'd0);
    chk("rst_ovf",  32'(ovf_m),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit, 2-bit digits
    issue(1'b0, 8'h5B, 8'h64, 1'b0, 1'b1); wait_drain();
    issue(1'b1, 8'h10, 8'h20, 1'b0, 1'b1); wait_drain();
    issue(1'b1, 8'h20, 8'h10, 1'b0, 1'b1); wait_drain();

    // Ignored start mid-run, then back-to-back from DONE
    issue(1'b0, 8'hFF, 8'h01, 1'b1, 1'b1);
    issue(1'b0, 8'h00, 8'h01, 1'b1, 1'b0);
    chk("hold_sum", 32'(sum_m), 32'h10);
    wait_done_pulse();
    issue(1'b0, 8'h7F, 8'h01, 1'b0, 1'b1);
    wait_drain();

    for (int i = 0; i < 6; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    // Reset in the middle of a run
    issue(1'b0, 8'h33, 8'h44, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_m), 32'd0);
    chk("mid_rst_done", 32'(done_m), 32'd0);
    chk("mid_rst_sum",  32'(sum_m),  32'd0);
    chk("mid_rst_cout", 32'(cout_m), 32'd0);
    chk("mid_rst_ovf",  32'(ovf_m),  32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_sum", 32'(sum_m), 32'd0);
    issue(1'b0, 8'h12, 8'h34, 1'b0, 1'b1); wait_drain();

    // 4-bit, 1-bit digits
    sel = 1;
    issue(1'b0, 8'h0B, 8'h04, 1'b1, 1'b1); wait_drain();
    for (int i = 0; i < 4; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    // 8-bit, single digit
    sel = 2;
    issue(1'b0, 8'h80, 8'h80, 1'b0, 1'b1); wait_drain();
    issue(1'b1, 8'h80, 8'h01, 1'b0, 1'b1); wait_drain();
    for (int i = 0; i < 4; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
